alu_top_core: RTL and testbench



---
 rtl/alu_pkg.sv | 64 ++++++
 rtl/alu32.sv | 58 +++++
 rtl/alu_top_core.sv | 66 ++++++
 tb/tb_alu_top_core.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU lab demonstrator:
//   - alu_op_e        : ALU_OP switch encodings (OP_AND .. OP_SLL)
//   - led_sel_e       : F_LED_SW switch encodings (byte lanes and flags view)
//   - operand_pair_t  : one preset {A, B} operand pair
//   - OPA_* / OPB_*   : the eight preset 32-bit operand constants
//   - operand_pair()  : maps an AB_SW code to its operand pair
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOR = 3'b011,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101,
        OP_SLT = 3'b110,
        OP_SLL = 3'b111
    } alu_op_e;

    // Codes 100..111 all select the flags view; only bit 2 matters for them.
    typedef enum logic [2:0] {
        LED_BYTE0  = 3'b000,
        LED_BYTE1  = 3'b001,
        LED_BYTE2  = 3'b010,
        LED_BYTE3  = 3'b011,
        LED_FLAGS0 = 3'b100,
        LED_FLAGS1 = 3'b101,
        LED_FLAGS2 = 3'b110,
        LED_FLAGS3 = 3'b111
    } led_sel_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } operand_pair_t;

    localparam logic [31:0] OPA_0 = 32'h0000_0000, OPB_0 = 32'h0000_0000;
    localparam logic [31:0] OPA_1 = 32'h0000_0003, OPB_1 = 32'h0000_0607;
    localparam logic [31:0] OPA_2 = 32'h8000_0000, OPB_2 = 32'h8000_0000;
    localparam logic [31:0] OPA_3 = 32'h7FFF_FFFF, OPB_3 = 32'h7FFF_FFFF;
    localparam logic [31:0] OPA_4 = 32'hFFFF_FFFF, OPB_4 = 32'hFFFF_FFFF;
    localparam logic [31:0] OPA_5 = 32'h8000_0000, OPB_5 = 32'hFFFF_FFFF;
    localparam logic [31:0] OPA_6 = 32'hFFFF_FFFF, OPB_6 = 32'h8000_0000;
    localparam logic [31:0] OPA_7 = 32'h1234_5678, OPB_7 = 32'h3333_2222;

    function automatic operand_pair_t operand_pair(input logic [2:0] sel);
        operand_pair_t p;
        case (sel)
            3'd0:    p = '{a: OPA_0, b: OPB_0};
            3'd1:    p = '{a: OPA_1, b: OPB_1};
            3'd2:    p = '{a: OPA_2, b: OPB_2};
            3'd3:    p = '{a: OPA_3, b: OPB_3};
            3'd4:    p = '{a: OPA_4, b: OPB_4};
            3'd5:    p = '{a: OPA_5, b: OPB_5};
            3'd6:    p = '{a: OPA_6, b: OPB_6};
            default: p = '{a: OPA_7, b: OPB_7};
        endcase
        return p;
    endfunction

endpackage : alu_pkg

// File: rtl/alu32.sv
// -----------------------------------------------------------------------------
// alu32
// Purely combinational 32-bit ALU.
// Ports:
//   A, B    in  [31:0]  operands
//   ALU_OP  in  [2:0]   operation select (alu_op_e)
//   F       out [31:0]  result
//   ZF      out         F == 0
//   OF      out         signed overflow, ADD and SUB only; 0 otherwise
// -----------------------------------------------------------------------------
module alu32
    import alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALU_OP,
    output logic [31:0] F,
    output logic        ZF,
    output logic        OF
);

    logic [31:0] sum;
    logic [31:0] diff;
    logic        slt;

    assign sum  = A + B;
    assign diff = A - B;
    assign slt  = $signed(A) < $signed(B);

    // NOTE: every signal written here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        F  = '0;
        OF = 1'b0;
        case (alu_op_e'(ALU_OP))
            OP_AND: F = A & B;
            OP_OR:  F = A | B;
            OP_XOR: F = A ^ B;
            OP_NOR: F = ~(A | B);
            OP_ADD: begin
                F  = sum;
                // Same-sign operands producing a result of the other sign.
                OF = (A[31] == B[31]) && (sum[31] != A[31]);
            end
            OP_SUB: begin
                F  = diff;
                // Opposite-sign operands whose result leaves A's sign.
                OF = (A[31] != B[31]) && (diff[31] != A[31]);
            end
            OP_SLT: F = {31'b0, slt};
            OP_SLL: F = B << A[4:0];   // upper bits of A deliberately unused
            default: F = '0;
        endcase
    end

    assign ZF = (F == 32'h0);

endmodule : alu32

// File: rtl/alu_top_core.sv
// -----------------------------------------------------------------------------
// alu_top_core
// Board-level ALU demonstrator: switch-selected operand pair and operation,
// with one byte of the result (or the flags) shown on 8 registered LEDs.
// Ports:
//   clk       in       system clock, rising edge
//   rst_n     in       asynchronous active-low reset, clears LED
//   AB_SW     in  [2:0] operand-pair select
//   ALU_OP    in  [2:0] operation select
//   F_LED_SW  in  [2:0] display select (byte 0..3, or {6'b0, OF, ZF})
//   LED       out [7:0] registered display value
// Switches are quasi-static, so they feed the combinational path directly.
// -----------------------------------------------------------------------------
module alu_top_core
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] AB_SW,
    input  logic [2:0] ALU_OP,
    input  logic [2:0] F_LED_SW,
    output logic [7:0] LED
);

    operand_pair_t ops;
    logic [31:0]   alu_f;
    logic          alu_zf;
    logic          alu_of;
    logic [7:0]    led_d;
    logic [7:0]    led_q;

    assign ops = operand_pair(AB_SW);

    alu32 u_alu32 (
        .A      (ops.a),
        .B      (ops.b),
        .ALU_OP (ALU_OP),
        .F      (alu_f),
        .ZF     (alu_zf),
        .OF     (alu_of)
    );

    always_comb begin
        led_d = 8'h00;
        case (led_sel_e'(F_LED_SW))
            LED_BYTE0: led_d = alu_f[7:0];
            LED_BYTE1: led_d = alu_f[15:8];
            LED_BYTE2: led_d = alu_f[23:16];
            LED_BYTE3: led_d = alu_f[31:24];
            default:   led_d = {6'b0, alu_of, alu_zf};
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= 8'h00;
        end else begin
            led_q <= led_d;
        end
    end

    assign LED = led_q;

endmodule : alu_top_core

// File: tb/tb_alu_top_core.sv
// -----------------------------------------------------------------------------
// tb_alu_top_core
// Directed, table-driven bench for alu_top_core with hand-computed expected
// LED values, plus hand-written latency and asynchronous-reset sequences.
// -----------------------------------------------------------------------------
module tb_alu_top_core;

    logic       clk;
    logic       rst_n;
    logic [2:0] ab_sw;
    logic [2:0] alu_op;
    logic [2:0] f_led_sw;
    logic [7:0] led;

    int total;
    int bad;

    typedef struct {
        string      name;
        logic [2:0] ab;
        logic [2:0] op;
        logic [2:0] fsel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    alu_top_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .AB_SW    (ab_sw),
        .ALU_OP   (alu_op),
        .F_LED_SW (f_led_sw),
        .LED      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
        end
    endtask

    // Drive switches away from the edge, then let one rising edge load LED.
    task automatic apply(input logic [2:0] ab, input logic [2:0] op, input logic [2:0] fs);
        @(negedge clk);
        ab_sw    = ab;
        alu_op   = op;
        f_led_sw = fs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // {name, AB_SW, ALU_OP, F_LED_SW, expected LED}
        vecs.push_back('{"add_ovf_b0",   3'b011, 3'b100, 3'b000, 8'hFE}); // F=FFFFFFFE
        vecs.push_back('{"add_ovf_flag", 3'b011, 3'b100, 3'b100, 8'h02}); // OF=1 ZF=0
        vecs.push_back('{"add_ovf_zero", 3'b010, 3'b100, 3'b100, 8'h03}); // F=0, OF=1
        vecs.push_back('{"xor_b0",       3'b111, 3'b010, 3'b000, 8'h5A}); // F=2107745A
        vecs.push_back('{"xor_b1",       3'b111, 3'b010, 3'b001, 8'h74});
        vecs.push_back('{"xor_b2",       3'b111, 3'b010, 3'b010, 8'h07});
        vecs.push_back('{"xor_b3",       3'b111, 3'b010, 3'b011, 8'h21});
        vecs.push_back('{"sub_neg_b3",   3'b101, 3'b101, 3'b011, 8'h80}); // F=80000001
        vecs.push_back('{"sub_neg_b0",   3'b101, 3'b101, 3'b000, 8'h01});
        vecs.push_back('{"sub_neg_flag", 3'b101, 3'b101, 3'b100, 8'h00}); // OF=0
        vecs.push_back('{"slt_true",     3'b101, 3'b110, 3'b000, 8'h01}); // -2^31 < -1
        vecs.push_back('{"slt_false",    3'b110, 3'b110, 3'b000, 8'h00}); // -1 < -2^31 no
        vecs.push_back('{"slt_pos",      3'b111, 3'b110, 3'b000, 8'h01});
        vecs.push_back('{"sll_b0",       3'b001, 3'b111, 3'b000, 8'h38}); // F=00003038
        vecs.push_back('{"sll_b1",       3'b001, 3'b111, 3'b001, 8'h30});
        vecs.push_back('{"sll_31_b3",    3'b100, 3'b111, 3'b011, 8'h80}); // F=80000000
        vecs.push_back('{"sll_31_flag",  3'b011, 3'b111, 3'b101, 8'h00});
        vecs.push_back('{"nor_zero",     3'b100, 3'b011, 3'b100, 8'h01}); // F=0
        vecs.push_back('{"nor_ones_b2",  3'b000, 3'b011, 3'b010, 8'hFF}); // F=FFFFFFFF
        vecs.push_back('{"and_b2",       3'b111, 3'b000, 3'b010, 8'h30}); // F=12300220
        vecs.push_back('{"or_b1",        3'b001, 3'b001, 3'b001, 8'h06}); // F=00000607
        vecs.push_back('{"add_b3",       3'b111, 3'b100, 3'b011, 8'h45}); // F=4567789A
        vecs.push_back('{"add_neg_flag", 3'b100, 3'b100, 3'b110, 8'h00}); // no overflow
        vecs.push_back('{"sub_b1",       3'b001, 3'b101, 3'b001, 8'hF9}); // F=FFFFF9FC
        vecs.push_back('{"sub_zero",     3'b000, 3'b101, 3'b111, 8'h01}); // ZF=1

        // Reset held with arbitrary switches and a running clock.
        rst_n    = 1'b0;
        ab_sw    = 3'b111;
        alu_op   = 3'b010;
        f_led_sw = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", led, 8'h00);

        // Release with AND of zeros, flags view: first edge loads ZF=1.
        @(negedge clk);
        ab_sw    = 3'b000;
        alu_op   = 3'b000;
        f_led_sw = 3'b100;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", led, 8'h01);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].ab, vecs[i].op, vecs[i].fsel);
            check(vecs[i].name, led, vecs[i].exp);
        end

        // Latency: a switch change between edges must not reach LED early.
        apply(3'b111, 3'b010, 3'b000);          // LED = 0x5A
        check("lat_base", led, 8'h5A);
        f_led_sw = 3'b011;                      // mid-cycle change to byte 3
        #2;
        check("lat_hold", led, 8'h5A);
        @(posedge clk);
        #1;
        check("lat_update", led, 8'h21);

        // All three banks change at once; one edge resolves them together.
        @(negedge clk);
        ab_sw    = 3'b011;
        alu_op   = 3'b100;
        f_led_sw = 3'b100;
        #1;
        check("simul_hold", led, 8'h21);
        @(posedge clk);
        #1;
        check("simul_update", led, 8'h02);

        // Async reset pulse between edges clears LED without a clock edge.
        apply(3'b001, 3'b111, 3'b000);          // LED = 0x38
        check("arst_base", led, 8'h38);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_clear", led, 8'h00);
        #1;
        rst_n = 1'b1;
        #1;
        check("arst_released_noedge", led, 8'h00);
        @(posedge clk);
        #1;
        check("arst_reload", led, 8'h38);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute watchdog so the bench always ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alu_top_core
